// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot iteration datapath and its controller.
package mandelbrot_pkg;

    // Default word width of c and z; fixed-point format 2.(WIDTH-2).
    localparam int DEF_WIDTH      = 8;
    // Default width of the iteration limit and iteration count.
    localparam int DEF_ITER_WIDTH = 6;

    // Q-format helpers for the default width: 1.0 == ONE.
    localparam int FRAC_BITS      = DEF_WIDTH - 2;
    localparam int ONE            = 1 << FRAC_BITS;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mandelbrot_iter_ctrl.sv
// Per-pixel iteration sequencer: takes a point c, runs z <- z^2 + c on an
// external ALU until escape or the iteration limit, then returns the count.
module mandelbrot_iter_ctrl
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ITER_WIDTH = DEF_ITER_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Point request from the pixel scanner
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_cr,
    input  logic [WIDTH-1:0]      in_ci,
    input  logic [ITER_WIDTH-1:0] in_max_iter,

    // Result to the consumer
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ITER_WIDTH-1:0] out_iter,
    output logic                  out_escaped,

    output logic                  busy,

    // ALU interface
    output logic                  alu_start,
    input  logic                  alu_finished,
    output logic [WIDTH-1:0]      alu_cr,
    output logic [WIDTH-1:0]      alu_ci,
    output logic [WIDTH-1:0]      alu_zr,
    output logic [WIDTH-1:0]      alu_zi,
    input  logic [WIDTH-1:0]      alu_out_zr,
    input  logic [WIDTH-1:0]      alu_out_zi,
    input  logic                  alu_size,
    input  logic                  alu_overflow
);

    state_t                r_state;
    state_t                w_next_state;

    logic [WIDTH-1:0]      r_cr;
    logic [WIDTH-1:0]      r_ci;
    logic [WIDTH-1:0]      r_zr;
    logic [WIDTH-1:0]      r_zi;
    logic [ITER_WIDTH-1:0] r_max_iter;
    logic [ITER_WIDTH-1:0] r_iter;
    logic                  r_escaped;

    logic                  w_escape;
    logic                  w_accept;
    logic [ITER_WIDTH-1:0] w_iter_inc;
    logic                  w_limit_hit;

    assign w_escape    = alu_size | alu_overflow;
    assign w_accept    = (r_state == ST_IDLE) && in_valid;
    assign w_iter_inc  = r_iter + ITER_WIDTH'(1);
    // Escape is tested first, so reaching the limit only counts a clean step.
    assign w_limit_hit = (w_iter_inc == r_max_iter);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake/ALU strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        alu_start    = 1'b0;
        busy         = 1'b1;

        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    // A zero limit finishes at once without touching the ALU.
                    w_next_state = (in_max_iter == '0) ? ST_DONE : ST_START;
                end
            end
            ST_START: begin
                alu_start    = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_finished) begin
                    if (w_escape || w_limit_hit) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_START;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Point/z/iteration datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cr       <= '0;
            r_ci       <= '0;
            r_zr       <= '0;
            r_zi       <= '0;
            r_max_iter <= '0;
            r_iter     <= '0;
            r_escaped  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cr       <= in_cr;
                r_ci       <= in_ci;
                r_max_iter <= in_max_iter;
                r_zr       <= '0;
                r_zi       <= '0;
                r_iter     <= '0;
                r_escaped  <= 1'b0;
            end else if ((r_state == ST_WAIT) && alu_finished) begin
                if (w_escape) begin
                    // Count stays at the last non-escaping step.
                    r_escaped <= 1'b1;
                end else begin
                    r_iter <= w_iter_inc;
                    // z only advances when another step will follow, so it
                    // is held steady for the ALU through START and WAIT.
                    if (!w_limit_hit) begin
                        r_zr <= alu_out_zr;
                        r_zi <= alu_out_zi;
                    end
                end
            end
        end
    end

    assign alu_cr      = r_cr;
    assign alu_ci      = r_ci;
    assign alu_zr      = r_zr;
    assign alu_zi      = r_zi;
    assign out_iter    = r_iter;
    assign out_escaped = r_escaped;

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Self-checking bench for mandelbrot_iter_ctrl with a behavioural ALU
// responder, a reference escape-time model and a scoreboard monitor.
module tb_mandelbrot_iter_ctrl;
    import mandelbrot_pkg::*;

    localparam int W  = 8;
    localparam int IW = 6;
    localparam int ZMAX = (1 << (W - 1)) - 1;
    localparam int ZMIN = -(1 << (W - 1));

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_cr;
    logic [W-1:0]  in_ci;
    logic [IW-1:0] in_max_iter;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_iter;
    logic          out_escaped;
    logic          busy;
    logic          alu_start;
    logic          alu_finished;
    logic [W-1:0]  alu_cr;
    logic [W-1:0]  alu_ci;
    logic [W-1:0]  alu_zr;
    logic [W-1:0]  alu_zi;
    logic [W-1:0]  alu_out_zr;
    logic [W-1:0]  alu_out_zi;
    logic          alu_size;
    logic          alu_overflow;

    mandelbrot_iter_ctrl #(.WIDTH(W), .ITER_WIDTH(IW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cr        (in_cr),
        .in_ci        (in_ci),
        .in_max_iter  (in_max_iter),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_iter     (out_iter),
        .out_escaped  (out_escaped),
        .busy         (busy),
        .alu_start    (alu_start),
        .alu_finished (alu_finished),
        .alu_cr       (alu_cr),
        .alu_ci       (alu_ci),
        .alu_zr       (alu_zr),
        .alu_zi       (alu_zi),
        .alu_out_zr   (alu_out_zr),
        .alu_out_zi   (alu_out_zi),
        .alu_size     (alu_size),
        .alu_overflow (alu_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int iter;
        int esc;
        int starts;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    // Each variable below has exactly one writing process.
    int   accept_id = 0;     // main: points handed to the DUT
    bit   count_en = 1'b1;   // main: responder counts starts / checks z
    int   lat_override = 0;  // main: fixed ALU latency when nonzero
    bit   rand_ready = 1'b0; // main: consumer back-pressure randomised
    bit   man_ready = 1'b1;  // main: manual out_ready
    bit   rnd_ready = 1'b1;  // randomiser process
    int   start_total = 0;   // responder

    assign out_ready = rand_ready ? rnd_ready : man_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One z <- z^2 + c step in 2.(W-2) fixed point, plus the escape flags.
    function automatic void alu_step(input int cr, input int ci, input int zr, input int zi,
                                     output int nr, output int ni,
                                     output bit size, output bit ovf);
        int zr2;
        int zi2;
        zr2  = zr * zr;
        zi2  = zi * zi;
        nr   = ((zr2 - zi2) >>> FRAC_BITS) + cr;
        ni   = ((2 * zr * zi) >>> FRAC_BITS) + ci;
        size = (zr2 + zi2) > (4 * ONE * ONE);
        ovf  = (nr > ZMAX) || (nr < ZMIN) || (ni > ZMAX) || (ni < ZMIN);
    endfunction

    // Escape-time reference: count clean steps from z = 0 up to the limit.
    function automatic exp_t ref_point(input int cr, input int ci, input int mx);
        exp_t r;
        int   zr;
        int   zi;
        int   nr;
        int   ni;
        bit   size;
        bit   ovf;
        r  = '{iter: 0, esc: 0, starts: 0};
        zr = 0;
        zi = 0;
        for (int k = 0; k < mx; k++) begin
            alu_step(cr, ci, zr, zi, nr, ni, size, ovf);
            if (size || ovf) begin
                r = '{iter: k, esc: 1, starts: k + 1};
                return r;
            end
            zr = nr;
            zi = ni;
        end
        r = '{iter: mx, esc: 0, starts: mx};
        return r;
    endfunction

    // Behavioural ALU: answers each start pulse after a short latency.
    initial begin : alu_model
        int cr;
        int ci;
        int zr;
        int zi;
        int nr;
        int ni;
        int lat;
        int checked_id;
        bit size;
        bit ovf;
        logic [W-1:0] zr_at_start;
        checked_id   = 0;
        alu_finished = 1'b0;
        alu_out_zr   = '0;
        alu_out_zi   = '0;
        alu_size     = 1'b0;
        alu_overflow = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && alu_start) begin
                cr = int'($signed(alu_cr));
                ci = int'($signed(alu_ci));
                zr = int'($signed(alu_zr));
                zi = int'($signed(alu_zi));
                zr_at_start = alu_zr;
                if (count_en) begin
                    start_total++;
                    if (checked_id != accept_id) begin
                        check("first_start_zr", alu_zr, 0);
                        check("first_start_zi", alu_zi, 0);
                        checked_id = accept_id;
                    end
                end
                alu_step(cr, ci, zr, zi, nr, ni, size, ovf);
                lat = (lat_override != 0) ? lat_override : int'($urandom_range(1, 3));
                repeat (lat) @(posedge clk);
                #1;
                if (count_en) check("alu_zr_stable", alu_zr, zr_at_start);
                alu_finished = 1'b1;
                alu_out_zr   = W'(nr);
                alu_out_zi   = W'(ni);
                alu_size     = size;
                alu_overflow = ovf;
                @(posedge clk);
                #1;
                alu_finished = 1'b0;
                alu_size     = 1'b0;
                alu_overflow = 1'b0;
            end
        end
    end

    // Random consumer back-pressure.
    initial begin : ready_randomiser
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor: compares each delivered result with the queue head.
    initial begin : monitor
        exp_t e;
        int   mark;
        mark = 0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_iter", out_iter, e.iter);
                    check("out_escaped", out_escaped, e.esc);
                    check("alu_start_count", start_total - mark, e.starts);
                end
                mark = start_total;
            end
        end
    end

    // Offer one point and wait for it to be accepted. Entered and left just
    // after a rising edge; keep_valid leaves in_valid asserted afterwards.
    task automatic send_point(input int cr, input int ci, input int mx, input bit keep_valid);
        int n;
        in_valid    = 1'b1;
        in_cr       = W'(cr);
        in_ci       = W'(ci);
        in_max_iter = IW'(mx);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 3000) begin
                check("accept_timeout", 1, 0);
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
        end
        sb_q.push_back(ref_point(cr, ci, mx));
        accept_id++;
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("drain_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int n;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_cr       = '0;
        in_ci       = '0;
        in_max_iter = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_start", alu_start, 0);
        check("rst_out_escaped", out_escaped, 0);
        check("rst_out_iter", out_iter, 0);
        check("rst_alu_zr", alu_zr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // c = 0 never escapes: full limit
        send_point(0, 0, 10, 1'b0);
        wait_idle();

        // c = 1.5 overflows on the second step
        send_point(ONE + ONE / 2, 0, 10, 1'b0);
        wait_idle();

        // Zero limit: result in the cycle after accept, no ALU activity
        send_point(37, -20, 0, 1'b0);
        @(negedge clk);
        check("max0_out_valid_next_cycle", out_valid, 1);
        wait_idle();

        // Back-pressure in DONE
        man_ready = 1'b0;
        send_point(0, 0, 10, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 2000);
        if (!out_valid) check("done_timeout", 1, 0);
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_out_iter", out_iter, 10);
            check("hold_in_ready", in_ready, 0);
            check("hold_alu_start", alu_start, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        man_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        check("release_busy", busy, 0);
        wait_idle();

        // Asynchronous reset during WAIT; the late ALU answer must be ignored
        count_en     = 1'b0;
        lat_override = 6;
        in_valid     = 1'b1;
        in_cr        = '0;
        in_ci        = '0;
        in_max_iter  = IW'(10);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("wait_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_alu_start", alu_start, 0);
        check("async_out_valid", out_valid, 0);
        check("async_busy", busy, 0);
        check("async_in_ready", in_ready, 1);
        @(negedge clk);
        check("rst_low_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("late_finish_busy", busy, 0);
        check("late_finish_out_valid", out_valid, 0);
        check("late_finish_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        lat_override = 0;
        count_en     = 1'b1;

        // Back-to-back points with in_valid held high, including the limits
        send_point(0, 0, 63, 1'b1);
        send_point(-ONE, 0, 5, 1'b1);
        send_point(20, 30, 0, 1'b1);
        send_point(ONE / 4, ONE / 2, 12, 1'b1);
        send_point(-2 * ONE, 0, 7, 1'b1);
        send_point(ZMAX, ZMIN, 3, 1'b0);
        wait_idle();

        // Randomised points under random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_point(int'($urandom_range(0, 180)) - 128,
                       int'($urandom_range(0, 160)) - 80,
                       ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 20)),
                       $urandom_range(0, 1) == 1);
        end
        in_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        rand_ready = 1'b0;
        man_ready  = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
